parity_tx: RTL and testbench
============================

# parity_tx

Serial transmitter producing parity-protected 4-bit frames. It accepts a data nibble and a parity-mode bit over a valid/ready handshake, computes the parity bit, and shifts out a 7-bit frame on a single idle-high line: start bit, 4 data bits LSB first, parity bit, stop bit. It is the sending end of the 4-bit parity link. A frame generated with mode `trig` passes a parity check performed with the same `trig`.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles each frame bit is held on `tx_out`; legal values ≥ 1.
- `clk` input 1: single clock; all logic is rising-edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `data` input 4: nibble to send; sampled only on acceptance.
- `trig` input 1: parity mode, sampled on acceptance. 0 → parity = XOR of data bits. 1 → parity = XNOR of data bits.
- `in_valid` input 1: `data` and `trig` are valid.
- `in_ready` output 1: block can accept a nibble.
- `tx_out` output 1: serial line; idles at 1.
- `busy` output 1: a frame is in progress.
- `done` output 1: one-cycle pulse during the last cycle of the stop bit.

## Operation
- States are IDLE, START, DATA, PARITY, STOP.
- IDLE
  - `tx_out`=1, `in_ready`=1, `busy`=0.
  - On a rising edge with `in_valid`&`in_ready`, latch `data` and `trig`, compute the parity bit, clear the bit timer, and go to START.
- START: `tx_out`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
- DATA
  - `tx_out`=`data_q[idx]`; each bit is held `CLKS_PER_BIT` cycles.
  - idx counts 0→3; after bit 3, go to PARITY.
- PARITY: `tx_out`=`par_q` for `CLKS_PER_BIT` cycles, then go to STOP.
- STOP: `tx_out`=1 for `CLKS_PER_BIT` cycles. `done`=1 in its final cycle, then go to IDLE.
- Inputs are ignored outside acceptance. Changes to `data`/`trig` mid-frame do not affect the frame in flight.
- All outputs are registered. Each output is a function of the registered state and counters only, with no combinational path from inputs.

## Timing
- Reset (`rst_n`=0 at a rising edge) has priority over everything, including acceptance. It sets state=IDLE, `tx_out`=1, `in_ready`=0, `busy`=0, `done`=0, and clears all counters.
- `in_ready` rises at the first rising edge with `rst_n`=1.
- Let E0 be the acceptance edge; frame cycles are numbered from 1 after E0.
  - Cycles 1..N are the start bit, where N=`CLKS_PER_BIT`.
  - Data bit k occupies cycles (k+1)N+1 .. (k+2)N.
  - The parity bit occupies cycles 5N+1..6N.
  - The stop bit occupies cycles 6N+1..7N.
- `busy`=1 and `in_ready`=0 over cycles 1..7N. `done`=1 only in cycle 7N.
- Cycle 7N+1 is IDLE with `in_ready`=1. With `in_valid` held high, the next acceptance edge is at the end of that cycle.
- Minimum frame period is therefore 7N+1 cycles.
- Reset mid-frame aborts the frame: no `done`, `tx_out`=1 the cycle after the reset edge.
- Bit timer counts 0..N-1 at width max(1,$clog2(N)). With N=1 every bit lasts exactly one cycle, and the timer is never compared against N.

## Structure
- Package `parity_pkg` holds:
  - the state enum typedef;
  - constants DATA_W=4, START_BIT=1'b0, STOP_BIT=1'b1, FRAME_BITS=7;
  - function `parity_calc(data, trig)` returning `^data` for trig=0 and `~^data` for trig=1.
- One sub-module, `bit_timer`, takes parameter N and inputs `clr` and `en`. It outputs `last`, asserted when count==N-1, and counts modulo N.
- The FSM, bit index, and output registers live in `parity_tx`.

## Test plan
- **Reset.** N=4; hold `rst_n`=0 for 3 cycles with `in_valid`=1, `data`=4'hF.
  - Required: `tx_out`=1, `in_ready`=0, `busy`=0, `done`=0 throughout.
  - Required: `in_ready`=1 one cycle after release, and the first acceptance occurs only then.
- **Odd-count nibble, trig=0.** `data`=4'b1011.
  - Required line sequence: 0,1,1,0,1,1,1, each held exactly 4 cycles (parity=1).
  - Required: `done` only in cycle 28.
- **Parity mode.** `data`=4'b1011 with trig=1 → parity bit 0. `data`=4'b0000 with trig=1 → parity bit 1. `data`=4'b0000 with trig=0 → parity bit 0.
- **Back-to-back and input stability.** `in_valid` held high; `data` changes from 4'h3 to 4'hC at cycle 10.
  - Required: the first frame carries 4'h3 unaltered.
  - Required: the second acceptance occurs exactly 29 cycles after the first, and the second frame carries 4'hC.
- **Reset mid-frame.** Assert `rst_n`=0 during data bit 2.
  - Required: next cycle `tx_out`=1, `busy`=0, `in_ready`=0; no `done` pulse.
  - Required: a new frame started after release is bit-exact.
- **N=1.** `data`=4'b0110, trig=0.
  - Required: a 7-cycle frame 0,0,1,1,0,0,1 with `done` in cycle 7; the next acceptance is possible at the end of cycle 8.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types, frame constants and the parity rule for the 4-bit parity link.
package parity_pkg;

  localparam int unsigned DATA_W     = 4;
  localparam logic        START_BIT  = 1'b0;
  localparam logic        STOP_BIT   = 1'b1;
  localparam int unsigned FRAME_BITS = 7;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // trig=0 gives even parity over data+parity, trig=1 gives odd.
  function automatic logic parity_calc(input logic [DATA_W-1:0] data, input logic trig);
    return trig ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit cycle counter: counts modulo N while enabled and flags the last cycle of a bit.
module bit_timer #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(N - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // With N=1 every cycle is the last one of its bit.
  assign last = (N == 1) ? 1'b1 : (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/parity_tx.sv
// Parity-protected serial transmitter: start, 4 data bits LSB first, parity, stop.
module parity_tx
  import parity_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data,
  input  logic              trig,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IdxW = $clog2(DATA_W);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              accept;
  logic              bit_last;

  assign accept = in_valid & ready_q;

  bit_timer #(
    .N(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (state_q != StIdle),
    .last (bit_last)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StStart;
          data_d  = data;
          par_d   = parity_calc(data, trig);
        end
      end
      StStart: begin
        if (bit_last) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_last) begin
          if (idx_q == IdxLast) begin
            state_d = StParity;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_last) begin
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from next-state so the line registers track the state register exactly.
  always_comb begin
    tx_d = STOP_BIT;
    unique case (state_d)
      StStart:  tx_d = START_BIT;
      StData:   tx_d = data_d[idx_d];
      StParity: tx_d = par_d;
      default:  tx_d = STOP_BIT;
    endcase
    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign tx_out   = tx_q;
  assign busy     = busy_q;
  assign in_ready = ready_q;
  assign done     = (state_q == StStop) && bit_last;

endmodule

// File: tb/tb_parity_tx.sv
// Self-checking bench for parity_tx at CLKS_PER_BIT=4 and CLKS_PER_BIT=1.
module tb_parity_tx;
  import parity_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] data4, data1;
  logic       trig4, trig1, valid4, valid1;
  logic       ready4, tx4, busy4, done4;
  logic       ready1, tx1, busy1, done1;

  int errors = 0;
  int checks = 0;

  logic [63:0] got_tx, got_done, got_busy;

  parity_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    (data4),
    .trig    (trig4),
    .in_valid(valid4),
    .in_ready(ready4),
    .tx_out  (tx4),
    .busy    (busy4),
    .done    (done4)
  );

  parity_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    (data1),
    .trig    (trig1),
    .in_valid(valid1),
    .in_ready(ready1),
    .tx_out  (tx1),
    .busy    (busy1),
    .done    (done1)
  );

  always #5 clk = ~clk;

  // Reference: frame slot = (cycle-1)/N; parity from counting ones.
  function automatic logic ref_bit(input logic [3:0] d, input logic t, input int c, input int n);
    int slot;
    int ones;
    slot = (c - 1) / n;
    ones = 0;
    for (int i = 0; i < 4; i++) ones += int'(d[i]);
    if (slot == 0) return 1'b0;
    if (slot <= 4) return d[slot-1];
    if (slot == 5) return ((ones % 2) == 1) ^ t;
    return 1'b1;
  endfunction

  function automatic logic [63:0] ref_line(input logic [3:0] d, input logic t, input int n);
    logic [63:0] v;
    v = '0;
    for (int c = 1; c <= int'(FRAME_BITS) * n; c++) v[c] = ref_bit(d, t, c, n);
    return v;
  endfunction

  function automatic logic [63:0] ref_done(input int n);
    logic [63:0] v;
    v = '0;
    v[int'(FRAME_BITS) * n] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] ref_busy(input int n);
    logic [63:0] v;
    v = '0;
    for (int c = 1; c <= int'(FRAME_BITS) * n; c++) v[c] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a nibble and steps until the acceptance edge; leaves in_valid high.
  task automatic accept(input int n, input logic [3:0] d, input logic t,
                        output int waited, output bit ok);
    logic rdy;
    if (n == 1) begin
      valid1 = 1'b1; data1 = d; trig1 = t;
    end else begin
      valid4 = 1'b1; data4 = d; trig4 = t;
    end
    waited = 0;
    ok = 1'b0;
    while (waited < 100) begin
      rdy = (n == 1) ? ready1 : ready4;
      step();
      waited++;
      if (rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Records cycles 1..7N of the frame in flight; ends in cycle 7N+1.
  task automatic capture(input int n, input int chg_cyc, input logic [3:0] chg_d);
    got_tx = '0;
    got_done = '0;
    got_busy = '0;
    for (int c = 1; c <= int'(FRAME_BITS) * n; c++) begin
      got_tx[c]   = (n == 1) ? tx1 : tx4;
      got_done[c] = (n == 1) ? done1 : done4;
      got_busy[c] = (n == 1) ? busy1 : busy4;
      if (c == chg_cyc) begin
        if (n == 1) data1 = chg_d;
        else data4 = chg_d;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid4 = 1'b1; data4 = 4'hF; trig4 = 1'b0;
    valid1 = 1'b0; data1 = 4'h0; trig1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({tx4, ready4, busy4, done4} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: tx/ready/busy/done=%b required 1000", i,
                 {tx4, ready4, busy4, done4});
      end
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({ready4, busy4} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: ready/busy=%b required 10", {ready4, busy4});
    end
    step();
    checks++;
    if ({busy4, ready4, tx4} !== 3'b100) begin
      errors++;
      $display("FAIL reset_first_accept: busy/ready/tx=%b required 100", {busy4, ready4, tx4});
    end
    valid4 = 1'b0;
    capture(4, 0, 4'h0);
    checks++;
    if (got_tx !== ref_line(4'hF, 1'b0, 4)) begin
      errors++;
      $display("FAIL reset_frame: line=%h required %h", got_tx, ref_line(4'hF, 1'b0, 4));
    end
  endtask

  task automatic test_odd_nibble();
    int w;
    bit ok;
    accept(4, 4'b1011, 1'b0, w, ok);
    valid4 = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL odd_accept: timed out after %0d cycles required acceptance", w);
    end
    capture(4, 0, 4'h0);
    checks++;
    if (got_tx !== ref_line(4'b1011, 1'b0, 4)) begin
      errors++;
      $display("FAIL odd_line: line=%h required %h", got_tx, ref_line(4'b1011, 1'b0, 4));
    end
    checks++;
    if (got_tx[24:21] !== 4'b1111) begin
      errors++;
      $display("FAIL odd_parity: parity cycles=%b required 1111", got_tx[24:21]);
    end
    checks++;
    if (got_done !== ref_done(4)) begin
      errors++;
      $display("FAIL odd_done: done=%h required %h", got_done, ref_done(4));
    end
    checks++;
    if (got_busy !== ref_busy(4)) begin
      errors++;
      $display("FAIL odd_busy: busy=%h required %h", got_busy, ref_busy(4));
    end
    checks++;
    if ({ready4, busy4, tx4} !== 3'b101) begin
      errors++;
      $display("FAIL odd_after: ready/busy/tx=%b required 101", {ready4, busy4, tx4});
    end
  endtask

  task automatic test_parity_mode();
    logic [3:0] pd[3];
    logic       pt[3];
    logic       pp[3];
    int w;
    bit ok;
    pd = '{4'b1011, 4'b0000, 4'b0000};
    pt = '{1'b1, 1'b1, 1'b0};
    pp = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      accept(4, pd[i], pt[i], w, ok);
      valid4 = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL mode_accept[%0d]: timed out after %0d cycles", i, w);
      end
      capture(4, 0, 4'h0);
      checks++;
      if (got_tx[24:21] !== {4{pp[i]}}) begin
        errors++;
        $display("FAIL mode_parity[%0d]: parity cycles=%b required %b", i, got_tx[24:21],
                 {4{pp[i]}});
      end
      checks++;
      if (got_tx !== ref_line(pd[i], pt[i], 4)) begin
        errors++;
        $display("FAIL mode_line[%0d]: line=%h required %h", i, got_tx,
                 ref_line(pd[i], pt[i], 4));
      end
    end
  endtask

  task automatic test_back_to_back();
    int w;
    bit ok;
    accept(4, 4'h3, 1'b0, w, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_accept1: timed out after %0d cycles", w);
    end
    capture(4, 10, 4'hC);
    checks++;
    if (got_tx !== ref_line(4'h3, 1'b0, 4)) begin
      errors++;
      $display("FAIL b2b_frame1: line=%h required %h", got_tx, ref_line(4'h3, 1'b0, 4));
    end
    accept(4, 4'hC, 1'b0, w, ok);
    valid4 = 1'b0;
    checks++;
    if (!ok || (28 + w) != 29) begin
      errors++;
      $display("FAIL b2b_period: accept gap=%0d ok=%0d required 29", 28 + w, ok);
    end
    capture(4, 0, 4'h0);
    checks++;
    if (got_tx !== ref_line(4'hC, 1'b0, 4)) begin
      errors++;
      $display("FAIL b2b_frame2: line=%h required %h", got_tx, ref_line(4'hC, 1'b0, 4));
    end
  endtask

  task automatic test_reset_mid();
    int w;
    bit ok;
    logic saw_done;
    logic [3:0] d;
    logic t;
    d = 4'($urandom_range(15, 0));
    t = 1'($urandom_range(1, 0));
    saw_done = 1'b0;
    accept(4, d, t, w, ok);
    valid4 = 1'b0;
    for (int c = 1; c < 14; c++) begin
      saw_done |= done4;
      step();
    end
    saw_done |= done4;
    rst_n = 1'b0;
    step();
    checks++;
    if ({tx4, busy4, ready4, done4} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_reset: tx/busy/ready/done=%b required 1000", {tx4, busy4, ready4, done4});
    end
    rst_n = 1'b1;
    step();
    saw_done |= done4;
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_done: done seen=%b required 0", saw_done);
    end
    d = 4'($urandom_range(15, 0));
    t = 1'($urandom_range(1, 0));
    accept(4, d, t, w, ok);
    valid4 = 1'b0;
    checks++;
    if (!ok || w != 1) begin
      errors++;
      $display("FAIL mid_reaccept: waited=%0d ok=%0d required 1", w, ok);
    end
    capture(4, 0, 4'h0);
    checks++;
    if (got_tx !== ref_line(d, t, 4)) begin
      errors++;
      $display("FAIL mid_new_frame: line=%h required %h", got_tx, ref_line(d, t, 4));
    end
  endtask

  task automatic test_random();
    int w;
    bit ok;
    logic [3:0] d;
    logic t;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(3, 0)) step();
      d = 4'($urandom_range(15, 0));
      t = 1'($urandom_range(1, 0));
      accept(4, d, t, w, ok);
      valid4 = 1'b0;
      data4 = ~d;
      trig4 = ~t;
      capture(4, 0, 4'h0);
      checks++;
      if (!ok || got_tx !== ref_line(d, t, 4)) begin
        errors++;
        $display("FAIL rand_line[%0d]: d=%h t=%b line=%h required %h", i, d, t, got_tx,
                 ref_line(d, t, 4));
      end
      checks++;
      if (got_done !== ref_done(4)) begin
        errors++;
        $display("FAIL rand_done[%0d]: done=%h required %h", i, got_done, ref_done(4));
      end
    end
  endtask

  task automatic test_n1();
    int w;
    bit ok;
    logic [6:0] exp7;
    logic [6:0] expd;
    logic [3:0] d;
    logic t;
    exp7 = 7'b1001100;
    expd = 7'b1000000;
    accept(1, 4'b0110, 1'b0, w, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL n1_accept: timed out after %0d cycles", w);
    end
    capture(1, 0, 4'h0);
    checks++;
    if (got_tx[7:1] !== exp7) begin
      errors++;
      $display("FAIL n1_line: line=%b required %b", got_tx[7:1], exp7);
    end
    checks++;
    if (got_done[7:1] !== expd) begin
      errors++;
      $display("FAIL n1_done: done=%b required %b", got_done[7:1], expd);
    end
    d = 4'($urandom_range(15, 0));
    t = 1'($urandom_range(1, 0));
    accept(1, d, t, w, ok);
    valid1 = 1'b0;
    checks++;
    if (!ok || w != 1) begin
      errors++;
      $display("FAIL n1_next_accept: waited=%0d ok=%0d required 1", w, ok);
    end
    capture(1, 0, 4'h0);
    checks++;
    if (got_tx !== ref_line(d, t, 1)) begin
      errors++;
      $display("FAIL n1_frame2: line=%h required %h", got_tx, ref_line(d, t, 1));
    end
  endtask

  initial begin
    test_reset();
    test_odd_nibble();
    test_parity_mode();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_n1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
